// File: rtl/wall_scroller.sv
// wall_scroller: keeps a small set of scrolling walls for the flappy-style game.
// Each accepted frame tick runs MOVE -> SPAWN -> CHECK -> DONE: walls shift left
// and retire, a new wall is spawned at the right edge from the height generator,
// and the fixed-column bird is tested against every active wall.
module wall_scroller #(
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int WALL_W    = 8,
  parameter int GAP       = 40,
  parameter int SPACING   = 48,
  parameter int SPEED     = 2,
  parameter int MAX_WALLS = 4,
  parameter int BIRD_X    = 30,
  parameter int BIRD_H    = 4,
  localparam int IDX_W    = (MAX_WALLS > 1) ? $clog2(MAX_WALLS) : 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             tick_i,
  input  logic [7:0]       height_in_i,
  output logic             height_ack_o,
  input  logic [6:0]       bird_y_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             wall_valid_o,
  output logic [7:0]       wall_x_o,
  output logic [6:0]       wall_top_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             hit_o
);

  localparam int TOP_MAX = SCREEN_H - GAP - 1;

  typedef enum logic [2:0] {IDLE, MOVE, SPAWN, CHECK, DONE} state_t;

  state_t                 state_q;
  logic [MAX_WALLS-1:0]   valid_q;
  logic [7:0]             xPos_q [MAX_WALLS];
  logic [6:0]             top_q  [MAX_WALLS];
  logic [7:0]             spawnCnt_q;
  logic [IDX_W-1:0]       spawnIdx_q;
  logic                   heightAck_q;
  logic                   frameDone_q;
  logic                   hit_q;

  logic [MAX_WALLS-1:0]   moveValid_d;
  logic [7:0]             moveX_d [MAX_WALLS];
  logic [7:0]             moveCnt_d;
  logic                   freeFound_d;
  logic [IDX_W-1:0]       freeIdx_d;
  logic [6:0]             topClamp_d;
  logic [MAX_WALLS-1:0]   collide_d;

  // Post-scroll slot state and spawn counter, plus the lowest slot left free by the scroll
  always_comb begin
    logic [8:0] cntSum;
    moveValid_d = valid_q;
    freeFound_d = 1'b0;
    freeIdx_d   = '0;
    for (int i = 0; i < MAX_WALLS; i++) begin
      moveX_d[i] = xPos_q[i];
      if (valid_q[i]) begin
        if ({1'b0, xPos_q[i]} < 9'(SPEED)) begin
          moveValid_d[i] = 1'b0;
        end else begin
          moveX_d[i] = xPos_q[i] - 8'(SPEED);
        end
      end
    end
    for (int i = MAX_WALLS - 1; i >= 0; i--) begin
      if (!moveValid_d[i]) begin
        freeFound_d = 1'b1;
        freeIdx_d   = IDX_W'(i);
      end
    end
    cntSum    = {1'b0, spawnCnt_q} + 9'(SPEED);
    moveCnt_d = (cntSum > 9'd255) ? 8'hFF : cntSum[7:0];
  end

  // Clamp the generator height so the whole gap stays on screen
  always_comb begin
    topClamp_d = (height_in_i <= 8'(TOP_MAX)) ? height_in_i[6:0] : 7'(TOP_MAX);
  end

  // Per-slot collision: bird column inside the wall and bird rows outside the gap
  always_comb begin
    logic [8:0] xExt;
    logic [7:0] birdTop;
    logic [7:0] birdBot;
    logic [7:0] gapTop;
    logic [7:0] gapBot;
    birdTop = {1'b0, bird_y_i};
    birdBot = birdTop + 8'(BIRD_H - 1);
    for (int i = 0; i < MAX_WALLS; i++) begin
      xExt   = {1'b0, xPos_q[i]};
      gapTop = {1'b0, top_q[i]};
      gapBot = gapTop + 8'(GAP - 1);
      collide_d[i] = valid_q[i]
                     && (xExt <= 9'(BIRD_X))
                     && (9'(BIRD_X) <= xExt + 9'(WALL_W - 1))
                     && ((birdTop < gapTop) || (birdBot > gapBot));
    end
  end

  // Frame sequencer: owns every slot register, the spawn counter and the registered pulses
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      for (int i = 0; i < MAX_WALLS; i++) begin
        xPos_q[i] <= '0;
        top_q[i]  <= '0;
      end
      spawnCnt_q  <= 8'(SPACING);
      spawnIdx_q  <= '0;
      heightAck_q <= 1'b0;
      frameDone_q <= 1'b0;
      hit_q       <= 1'b0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      spawnCnt_q  <= 8'(SPACING);
      heightAck_q <= 1'b0;
      frameDone_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      heightAck_q <= 1'b0;
      frameDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick_i && enable_i) begin
            state_q <= MOVE;
          end
        end
        MOVE: begin
          valid_q    <= moveValid_d;
          spawnCnt_q <= moveCnt_d;
          for (int i = 0; i < MAX_WALLS; i++) begin
            xPos_q[i] <= moveX_d[i];
          end
          if ((moveCnt_d >= 8'(SPACING)) && freeFound_d) begin
            heightAck_q <= 1'b1;
            spawnIdx_q  <= freeIdx_d;
          end
          state_q <= SPAWN;
        end
        SPAWN: begin
          if (heightAck_q) begin
            valid_q[spawnIdx_q] <= 1'b1;
            xPos_q[spawnIdx_q]  <= 8'(SCREEN_W);
            top_q[spawnIdx_q]   <= topClamp_d;
            spawnCnt_q          <= '0;
          end
          state_q <= CHECK;
        end
        CHECK: begin
          if (|collide_d) begin
            hit_q <= 1'b1;
          end
          frameDone_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Draw port and status outputs straight from registered state
  always_comb begin
    wall_valid_o = valid_q[rd_idx_i];
    wall_x_o     = xPos_q[rd_idx_i];
    wall_top_o   = top_q[rd_idx_i];
    busy_o       = (state_q != IDLE);
    height_ack_o = heightAck_q;
    frame_done_o = frameDone_q;
    hit_o        = hit_q;
  end

endmodule

// File: tb/tb_wall_scroller.sv
// tb_wall_scroller: directed frames with hand-chosen heights, bird rows, ack and hit
// expectations; a slot model supplies expected wall contents. Expectations are queued
// at each tick and a monitor pops one whenever frame_done appears.
module tb_wall_scroller;

  logic       clock = 1'b0;
  logic       resetn;
  logic       clear;
  logic       enable;
  logic       tick;
  logic [7:0] heightIn;
  logic       heightAck;
  logic [6:0] birdY;
  logic [1:0] rdIdx;
  logic       wallValid;
  logic [7:0] wallX;
  logic [6:0] wallTop;
  logic       busy;
  logic       frameDone;
  logic       hit;

  typedef struct packed {
    logic [31:0]     tickCycle;
    logic            expAck;
    logic            expHit;
    logic [3:0]      v;
    logic [3:0][7:0] x;
    logic [3:0][6:0] top;
  } exp_t;

  exp_t sb[$];
  exp_t monItem;

  int assertions   = 0;
  int failures     = 0;
  int cycleCount   = 0;
  int ackCount     = 0;
  int ackCountSeen = 0;
  int lastAckCycle = -1;
  int frameNo      = 0;

  bit mValid[4];
  int mX[4];
  int mTop[4];
  int mCnt;
  bit mHit;

  wall_scroller dut (
    .clock        (clock),
    .resetn       (resetn),
    .clear_i      (clear),
    .enable_i     (enable),
    .tick_i       (tick),
    .height_in_i  (heightIn),
    .height_ack_o (heightAck),
    .bird_y_i     (birdY),
    .rd_idx_i     (rdIdx),
    .wall_valid_o (wallValid),
    .wall_x_o     (wallX),
    .wall_top_o   (wallTop),
    .busy_o       (busy),
    .frame_done_o (frameDone),
    .hit_o        (hit)
  );

  // 10-unit clock
  always #5 clock = ~clock;

  // Cycle index used for latency checks
  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Record every height_ack pulse and the cycle it appeared in
  always @(negedge clock) begin
    if (heightAck) begin
      ackCount     = ackCount + 1;
      lastAckCycle = cycleCount;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mValid[i] = 1'b0;
      mX[i]     = 0;
      mTop[i]   = 0;
    end
    mCnt = 48;
    mHit = 1'b0;
  endtask

  task automatic modelClear();
    for (int i = 0; i < 4; i++) mValid[i] = 1'b0;
    mCnt = 48;
    mHit = 1'b0;
  endtask

  task automatic modelFrame(input int height, input int by);
    int slot;
    for (int i = 0; i < 4; i++) begin
      if (mValid[i]) begin
        if (mX[i] < 2) mValid[i] = 1'b0;
        else           mX[i] = mX[i] - 2;
      end
    end
    mCnt = (mCnt + 2 > 255) ? 255 : mCnt + 2;
    if (mCnt >= 48) begin
      slot = -1;
      for (int i = 3; i >= 0; i--) if (!mValid[i]) slot = i;
      if (slot >= 0) begin
        mValid[slot] = 1'b1;
        mX[slot]     = 160;
        mTop[slot]   = (height > 79) ? 79 : height;
        mCnt         = 0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (mValid[i] && mX[i] <= 30 && 30 <= mX[i] + 7 &&
          (by < mTop[i] || by + 3 > mTop[i] + 39)) mHit = 1'b1;
    end
  endtask

  // One frame: drive tick, queue the expected result, optionally poke a tick while busy
  task automatic applyStimulus(input int height, input int by, input bit expAck,
                               input bit expHit, input bit busyTick);
    exp_t e;
    @(negedge clock);
    heightIn = 8'(height);
    birdY    = 7'(by);
    tick     = 1'b1;
    e.tickCycle = 32'(cycleCount);
    @(negedge clock);
    tick = 1'b0;
    modelFrame(height, by);
    e.expAck = expAck;
    e.expHit = expHit;
    for (int i = 0; i < 4; i++) begin
      e.v[i]   = mValid[i];
      e.x[i]   = 8'(mX[i]);
      e.top[i] = 7'(mTop[i]);
    end
    sb.push_back(e);
    if (busyTick) begin
      @(negedge clock);
      checkOutput("busy during frame", busy, 1);
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
    end
    repeat (5) @(negedge clock);
  endtask

  // Monitor: on each frame_done pop one expectation and compare timing, hit and all slots
  initial begin
    rdIdx = 2'd0;
    forever begin
      @(negedge clock);
      if (frameDone) begin
        frameNo++;
        if (sb.size() == 0) begin
          checkOutput("unexpected frame_done", 1, 0);
        end else begin
          monItem = sb.pop_front();
          checkOutput($sformatf("f%0d frame_done latency", frameNo),
                      cycleCount - int'(monItem.tickCycle), 4);
          checkOutput($sformatf("f%0d hit", frameNo), hit, monItem.expHit);
          checkOutput($sformatf("f%0d height_ack count", frameNo),
                      ackCount - ackCountSeen, monItem.expAck);
          if (monItem.expAck)
            checkOutput($sformatf("f%0d height_ack cycle", frameNo),
                        lastAckCycle - int'(monItem.tickCycle), 2);
          for (int i = 0; i < 4; i++) begin
            rdIdx = 2'(i);
            #1;
            checkOutput($sformatf("f%0d slot%0d valid", frameNo, i), wallValid, monItem.v[i]);
            checkOutput($sformatf("f%0d slot%0d x", frameNo, i), wallX, monItem.x[i]);
            checkOutput($sformatf("f%0d slot%0d top", frameNo, i), wallTop, monItem.top[i]);
          end
        end
        ackCountSeen = ackCount;
      end
    end
  end

  // Directed sequence
  initial begin
    int h;
    resetn   = 1'b0;
    clear    = 1'b0;
    enable   = 1'b1;
    tick     = 1'b0;
    heightIn = 8'd0;
    birdY    = 7'd40;
    modelReset();
    repeat (3) @(negedge clock);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset hit", hit, 0);
    checkOutput("reset frame_done", frameDone, 0);
    checkOutput("reset height_ack", heightAck, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Spawn/scroll/retire/reuse/clamp run; bird at row 40 clears every wall
    for (int k = 1; k <= 121; k++) begin
      if (k == 1)        h = 30;
      else if (k <= 25)  h = 10;
      else if (k == 97)  h = 93;
      else if (k == 121) h = 79;
      else               h = 30;
      applyStimulus(h, 40, (k % 24) == 1, 1'b0, 1'b0);
    end

    // Second tick while busy must be dropped
    applyStimulus(30, 40, 1'b0, 1'b0, 1'b1);

    // Tick with enable low is ignored
    @(negedge clock);
    enable = 1'b0;
    tick   = 1'b1;
    @(negedge clock);
    tick   = 1'b0;
    enable = 1'b1;
    repeat (6) @(negedge clock);
    checkOutput("tick with enable low", busy, 0);

    // clear together with tick: no frame, slots emptied
    @(negedge clock);
    clear = 1'b1;
    tick  = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    tick  = 1'b0;
    modelClear();
    repeat (8) @(negedge clock);
    checkOutput("clear+tick busy", busy, 0);

    // Wall top 50 scrolled to x=28 (tick 67); bird 48 at x=26 hits, then stays sticky
    for (int k = 1; k <= 69; k++) begin
      applyStimulus(50, (k == 68) ? 48 : 60, (k % 24) == 1, k >= 68, 1'b0);
    end
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    modelClear();
    checkOutput("hit after clear", hit, 0);

    // Rebuild; bird 88 at x=28 overlaps the bottom gap edge
    for (int k = 1; k <= 72; k++) begin
      applyStimulus(50, (k == 67) ? 88 : 60, (k % 24) == 1, k >= 67, 1'b0);
    end

    // Frame 73 would spawn into slot3; reset lands in the SPAWN cycle
    @(negedge clock);
    heightIn = 8'd50;
    birdY    = 7'd60;
    tick     = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    @(posedge clock);
    #2;
    checkOutput("pending spawn ack", heightAck, 1);
    resetn = 1'b0;
    #1;
    checkOutput("reset mid-frame busy", busy, 0);
    checkOutput("reset mid-frame height_ack", heightAck, 0);
    checkOutput("reset mid-frame hit", hit, 0);
    checkOutput("reset mid-frame frame_done", frameDone, 0);
    @(negedge clock);
    resetn = 1'b1;
    modelReset();
    repeat (2) @(negedge clock);

    // First frame after reset spawns into slot0, other slots at reset values
    applyStimulus(30, 40, 1'b1, 1'b0, 1'b0);

    for (int t = 0; t < 50 && sb.size() > 0; t++) @(negedge clock);
    checkOutput("frames never completed", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/wall_scroller.md
# wall_scroller

Downstream consumer of the LFSR wall-height source. Holds up to MAX_WALLS active walls, each with an x position and a gap-top height. On every frame tick it scrolls all walls left and retires those that leave the screen. It spawns a new wall at the right edge from the sampled height once the spacing distance has been covered, and then evaluates bird/wall collision. Sits between the height generator and the VGA draw and game-control logic.

## Interface
- SCREEN_W, 160: playfield width in pixels; also the spawn x position
- SCREEN_H, 120: playfield height in pixels
- WALL_W, 8: wall width in pixels
- GAP, 40: vertical opening height in pixels
- SPACING, 48: scrolled pixels between spawns
- SPEED, 2: pixels moved per tick
- MAX_WALLS, 4: number of wall slots
- BIRD_X, 30: fixed bird column
- BIRD_H, 4: bird height in pixels
- clock, in, 1: system clock
- resetn, in, 1: reset, asynchronous, active-low
- clear, in, 1: synchronous restart; empties all slots and clears hit
- enable, in, 1: gates tick; ticks while low are ignored
- tick, in, 1: one-cycle frame pulse
- height_in, in, 8: current height from the generator
- height_ack, out, 1: one-cycle pulse; height_in consumed, generator may advance
- bird_y, in, 7: top row of the bird
- rd_idx, in, 2: slot select for the draw port
- wall_valid, out, 1: selected slot occupied (combinational from rd_idx)
- wall_x, out, 8: left edge of the selected slot (combinational)
- wall_top, out, 7: gap top row of the selected slot (combinational)
- busy, out, 1: high whenever the FSM is not in IDLE
- frame_done, out, 1: one-cycle pulse at the end of each processed frame
- hit, out, 1: sticky collision flag

## Operation
- Per-slot registers: valid, x[7:0], top[6:0].
- Also holds spawn_cnt[7:0].
- FSM states: IDLE, MOVE, SPAWN, CHECK, DONE.
- IDLE → MOVE when tick && enable. Otherwise stay in IDLE.
- MOVE, for each valid slot:
  - if x < SPEED, clear valid;
  - else x ← x − SPEED.
  - Also spawn_cnt ← min(spawn_cnt + SPEED, 255).
- SPAWN, when spawn_cnt ≥ SPACING and a free slot exists:
  - use the lowest-index free slot;
  - set valid=1, x=SCREEN_W, top=clamp(height_in);
  - set spawn_cnt ← 0 and pulse height_ack.
- SPAWN with no free slot: no write and no ack. spawn_cnt holds, so the spawn is retried next frame.
- Height clamp: top = height_in if height_in ≤ SCREEN_H−GAP−1, else SCREEN_H−GAP−1. The value is truncated to 7 bits after the clamp.
- CHECK: a slot collides when all of the following hold:
  - it is valid;
  - x ≤ BIRD_X ≤ x+WALL_W−1;
  - bird_y < top, or bird_y+BIRD_H−1 > top+GAP−1.
- CHECK: any colliding slot sets hit. hit stays set until clear or reset.
- DONE: pulse frame_done, then return to IDLE.
- Arithmetic width:
  - all x compares use 9 bits, so x+WALL_W−1 cannot wrap;
  - bird compares use 8 bits.
- Ticks arriving while busy are dropped. No queueing.
- clear: takes effect in any state, with priority over tick.
  - slots invalid, hit=0, spawn_cnt=SPACING, FSM → IDLE;
  - no frame_done or height_ack is emitted on that cycle.
- enable falling mid-frame does not abort the frame.

## Timing
- Reset values:
  - FSM in IDLE; all slots valid=0, x=0, top=0;
  - spawn_cnt=SPACING, so the first frame spawns;
  - height_ack=0, frame_done=0, hit=0, busy=0.
- Sequence when tick is accepted in cycle N:
  - MOVE in N+1;
  - SPAWN in N+2, with height_ack high in N+2 and height_in sampled at the N+2 edge;
  - CHECK in N+3;
  - DONE in N+4, with frame_done high in N+4 and hit already updated.
- Back in IDLE at N+5. Minimum tick period: 5 cycles.
- busy is high in cycles N+1 through N+4.
- The draw port is combinational from registered state. Values are stable while busy is low.
- resetn asserted mid-frame returns everything to reset values immediately.

## Test plan
- Reset, then tick with height_in=30:
  - frame_done 4 cycles after tick, height_ack pulse in the SPAWN cycle;
  - slot0 valid, x=160, top=30; hit=0.
- 24 ticks with height_in=10:
  - slot0 reaches x=112 and slot1 spawns at x=160 on tick 25;
  - slot1 spawn is confirmed by spawn_cnt returning to 0.
- Scroll slot0 from 160 to x=0 and tick once more:
  - slot0 valid=0;
  - a later spawn reuses slot0 (lowest free index).
- height_in=93:
  - top clamps to 79 and the gap ends at row 118;
  - height_in=79 stores 79 unchanged.
- Wall at x=28, top=50, gap rows 50..89:
  - bird_y=60 gives hit=0;
  - bird_y=48 or bird_y=88 gives hit=1, which stays sticky until clear pulses.
- Edge cases:
  - tick during busy: ignored, exactly one frame_done;
  - clear in the same cycle as tick: all slots empty, no frame_done;
  - resetn during SPAWN: no slot written and outputs at reset values.
